// File: rtl/upsample_pkg.sv
// upsample_pkg: shared types and constants for the 20 -> 122.88 MSPS upsampler.
package upsample_pkg;

    localparam int LANE_W = 16;

    typedef struct packed {
        logic signed [LANE_W-1:0] i;
        logic signed [LANE_W-1:0] q;
    } iq_t;

    typedef enum logic [1:0] {EMPTY, PRIME, RUN} state_t;

    // 64-bit so that small output rates (large scales) still fit.
    function automatic logic [63:0] mu_scale(input int rate_out, input int frac_bits);
        return (64'd1 << (32 + frac_bits)) / 64'(rate_out);
    endfunction

endpackage

// File: rtl/upsample_if.sv
// upsample_if: AXI-Stream valid/ready/data bundle used on both sides of the upsampler.
interface upsample_if
    import upsample_pkg::*;
#(
    parameter int DW = $bits(iq_t)
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/upsample_interp_lane.sv
// interp_lane: one signed lane of x0 + round((x1 - x0) * mu), three enabled stages.
module interp_lane
    import upsample_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [LANE_W-1:0] x0,
    input  logic signed [LANE_W-1:0] x1,
    input  logic [FRAC_BITS-1:0]     mu,
    output logic signed [LANE_W-1:0] y
);

    localparam int PW = LANE_W + 2 + FRAC_BITS;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (FRAC_BITS - 1));

    logic signed [LANE_W:0]   d_q, d_d;
    logic [FRAC_BITS-1:0]     mu_q;
    logic signed [LANE_W-1:0] x0_s1_q, x0_s2_q, y_q, y_d;
    logic signed [PW-1:0]     p_q, p_d;

    always_comb begin
        d_d = (LANE_W + 1)'(x1) - (LANE_W + 1)'(x0);
        p_d = PW'(d_q) * PW'($signed({1'b0, mu_q}));
        y_d = LANE_W'(PW'(x0_s2_q) + ((p_q + RND) >>> FRAC_BITS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            mu_q    <= '0;
            x0_s1_q <= '0;
            p_q     <= '0;
            x0_s2_q <= '0;
            y_q     <= '0;
        end else if (en) begin
            d_q     <= d_d;
            mu_q    <= mu;
            x0_s1_q <= x0;
            p_q     <= p_d;
            x0_s2_q <= x0_s1_q;
            y_q     <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/upsample.sv
// upsample: fractional-rate linear-interpolating I/Q upsampler driven by an exact phase accumulator.
module upsample
    import upsample_pkg::*;
#(
    parameter int SAMPLE_RATE_IN         = 20_000,
    parameter int SAMPLE_RATE_OUT        = 122_880,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int FRAC_BITS              = 16
) (
    input  logic      s00_axis_aclk,
    input  logic      s00_axis_aresetn,
    upsample_if.slave  s00_axis,
    upsample_if.master m00_axis
);

    localparam int PW = $clog2(SAMPLE_RATE_OUT) + 1;
    localparam logic [PW-1:0] RATE_IN  = PW'(SAMPLE_RATE_IN);
    localparam logic [PW-1:0] RATE_OUT = PW'(SAMPLE_RATE_OUT);
    localparam logic [63:0]   MU_SCALE = mu_scale(SAMPLE_RATE_OUT, FRAC_BITS);

    state_t                   state_q, state_d;
    logic [PW-1:0]            phase_q, phase_d, pn;
    iq_t                      x0_q, x0_d, x1_q, x1_d, in_iq;
    logic [2:0]               vld_q, vld_d;
    logic                     en, ready, emit;
    logic [FRAC_BITS-1:0]     mu;
    logic signed [LANE_W-1:0] y_i, y_q;

    assign en    = ~vld_q[2] | m00_axis.tready;
    assign in_iq = s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1 -: $bits(iq_t)];
    assign pn    = phase_q + RATE_IN;
    assign mu    = FRAC_BITS'(((PW + 64)'(phase_q) * (PW + 64)'(MU_SCALE)) >> 32);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        x0_d    = x0_q;
        x1_d    = x1_q;
        ready   = 1'b0;
        emit    = 1'b0;
        if (en) begin
            case (state_q)
                EMPTY: begin
                    ready = 1'b1;
                    if (s00_axis.tvalid) begin
                        x0_d    = in_iq;
                        state_d = PRIME;
                    end
                end
                PRIME: begin
                    ready = 1'b1;
                    if (s00_axis.tvalid) begin
                        x1_d    = in_iq;
                        phase_d = '0;
                        state_d = RUN;
                    end
                end
                default: begin
                    // Crossing into the next input interval needs a fresh sample; otherwise a bubble.
                    if (pn < RATE_OUT) begin
                        emit    = 1'b1;
                        phase_d = pn;
                    end else begin
                        ready = 1'b1;
                        if (s00_axis.tvalid) begin
                            emit    = 1'b1;
                            x0_d    = x1_q;
                            x1_d    = in_iq;
                            phase_d = pn - RATE_OUT;
                        end
                    end
                end
            endcase
        end
        vld_d = en ? {vld_q[1:0], emit} : vld_q;
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q <= EMPTY;
            phase_q <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            vld_q   <= vld_d;
        end
    end

    interp_lane #(.FRAC_BITS(FRAC_BITS)) u_lane_i (
        .clk   (s00_axis_aclk),
        .rst_n (s00_axis_aresetn),
        .en    (en),
        .x0    (x0_q.i),
        .x1    (x1_q.i),
        .mu    (mu),
        .y     (y_i)
    );

    interp_lane #(.FRAC_BITS(FRAC_BITS)) u_lane_q (
        .clk   (s00_axis_aclk),
        .rst_n (s00_axis_aresetn),
        .en    (en),
        .x0    (x0_q.q),
        .x1    (x1_q.q),
        .mu    (mu),
        .y     (y_q)
    );

    assign s00_axis.tready = ready & s00_axis_aresetn;
    assign m00_axis.tvalid = vld_q[2];
    assign m00_axis.tdata  = C_M00_AXIS_TDATA_WIDTH'({y_i, y_q});

endmodule

// File: tb/tb_upsample.sv
// tb_upsample: table-driven ramp and randomized stream checks of upsample against a rate-conversion model.
module tb_upsample;
    import upsample_pkg::*;

    localparam int          RIN   = 20_000;
    localparam int          ROUT  = 122_880;
    localparam longint      MUS   = (longint'(1) <<< 48) / ROUT;
    localparam logic [31:0] CONST = {16'sd1000, -16'sd1000};

    typedef struct {
        logic [15:0]       in_i;
        logic [3:0][15:0]  exp_i;
    } ramp_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    upsample_if #(.DW(32)) s_if (), m_if (), rs_if (), rm_if ();

    upsample dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis         (s_if),
        .m00_axis         (m_if)
    );

    upsample #(.SAMPLE_RATE_IN(1), .SAMPLE_RATE_OUT(4)) dut_r (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .s00_axis         (rs_if),
        .m00_axis         (rm_if)
    );

    int          vecs = 0, errs = 0;
    logic [31:0] xs[$];
    int          k_out = 0;
    logic [31:0] nxt;
    bit          const_mode, held_v, last_acc, last_out, gap_on;
    logic [31:0] held_d;
    int          gap, gap_arm;
    ramp_vec_t   tab [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic expect_true(input string name, input bit ok, input longint act, input string req);
        vecs++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %0d, required %s", name, act, req);
        end
    endtask

    function automatic logic [15:0] lerp(input logic [15:0] a, input logic [15:0] b, input longint mu);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        return 16'(sa + ((((sb - sa) * mu) + 32768) >>> 16));
    endfunction

    // Output k sits at input time k*RIN/ROUT: between samples n and n+1 at fractional phase.
    function automatic logic [31:0] interp(input logic [31:0] a, input logic [31:0] b, input longint ph);
        longint mu = (ph * MUS) >>> 32;
        return {lerp(a[31:16], b[31:16], mu), lerp(a[15:0], b[15:0], mu)};
    endfunction

    // Output k needs sample floor((k+1)*RIN/ROUT)+1, so with n samples this many outputs exist.
    function automatic int exp_count(input int n);
        return (n < 2) ? 0 : int'((longint'(n - 1) * ROUT + RIN - 1) / RIN - 1);
    endfunction

    task automatic step(input bit vin, input bit rdy);
        longint pos;
        int     n;
        @(negedge clk);
        if (held_v) begin
            chk("stall_tvalid", 32'(m_if.tvalid), 32'd1);
            chk("stall_tdata", m_if.tdata, held_d);
        end
        s_if.tvalid = vin;
        s_if.tdata  = nxt;
        m_if.tready = rdy;
        #1;
        last_out = m_if.tvalid && rdy;
        last_acc = vin && s_if.tready;
        if (m_if.tvalid && !rdy) chk("stall_wins_tready", 32'(s_if.tready), 32'd0);
        if (last_out) begin
            pos = longint'(k_out) * RIN;
            n   = int'(pos / ROUT);
            if (n + 1 >= xs.size()) expect_true("early_output", 1'b0, k_out, "input sample available");
            else chk("out_data", m_if.tdata, interp(xs[n], xs[n + 1], pos % ROUT));
            k_out++;
            gap++;
        end
        if (last_acc) begin
            xs.push_back(nxt);
            nxt = const_mode ? CONST : $urandom;
            if (gap_on) begin
                if (gap_arm >= 2) expect_true("accept_spacing", gap == 6 || gap == 7, gap, "6 or 7");
                gap_arm++;
            end
            gap = 0;
        end
        held_v = m_if.tvalid && !rdy;
        held_d = m_if.tdata;
    endtask

    initial begin
        int acc2, first, ra, ro, ri, st;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        m_if.tready  = 1'b0;
        rs_if.tvalid = 1'b0;
        rs_if.tdata  = '0;
        rm_if.tready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            tab[r].in_i = 16'(4000 * r);
            for (int j = 0; j < 4; j++) tab[r].exp_i[j] = 16'(4000 * r + 1000 * j);
        end
        #2;
        chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst_tready", 32'(s_if.tready), 32'd0);
        chk("rst_tdata", m_if.tdata, 32'd0);
        chk("rst_ramp_tready", 32'(rs_if.tready), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("release_tready", 32'(s_if.tready), 32'd1);
        m_if.tready = 1'b1;

        // Ramp on the 1:4 instance: each input interval yields four evenly spaced points.
        ra = 0;
        ro = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ri = (ra < 5) ? ra : 4;
            rs_if.tvalid = (ra < 5);
            rs_if.tdata  = {tab[ri].in_i, 16'(16'd0 - tab[ri].in_i)};
            rm_if.tready = 1'b1;
            #1;
            if (rm_if.tvalid) begin
                if (ro < 15) begin
                    chk("ramp_i", {16'd0, rm_if.tdata[31:16]}, {16'd0, tab[ro / 4].exp_i[ro % 4]});
                    chk("ramp_q", {16'd0, rm_if.tdata[15:0]}, {16'd0, 16'(16'd0 - tab[ro / 4].exp_i[ro % 4])});
                end
                ro++;
            end
            if (rs_if.tvalid && rs_if.tready) ra++;
        end
        chk("ramp_count", 32'(ro), 32'd15);

        // Prime with a constant stream and measure first-output latency.
        const_mode = 1'b1;
        nxt   = CONST;
        acc2  = -100;
        first = -1;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'b1);
            if (last_acc && xs.size() == 2) acc2 = c;
            if (last_out && first < 0) begin
                first = c;
                chk("prime_first", m_if.tdata, CONST);
            end
        end
        chk("prime_latency_edges", 32'(first - acc2 - 1), 32'd3);

        // Continuous random stream: accept cadence and exact output count.
        const_mode = 1'b0;
        nxt     = $urandom;
        gap_on  = 1'b1;
        gap_arm = 0;
        repeat (3000) step(1'b1, 1'b1);
        gap_on = 1'b0;
        repeat (20) step(1'b0, 1'b1);
        chk("drain_count", 32'(k_out), 32'(exp_count(xs.size())));

        // Random backpressure and input gaps, including simultaneous stall and starvation.
        repeat (3000) step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        repeat (10) step(1'b1, 1'b1);

        // Starvation in RUN: only the remaining phases of the current interval come out.
        st = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b1);
            if (c >= 3 && last_out) st++;
        end
        expect_true("starve_outputs", st <= 6, st, "<= 6");
        chk("starve_count", 32'(k_out), 32'(exp_count(xs.size())));
        chk("starve_tvalid", 32'(m_if.tvalid), 32'd0);
        repeat (200) step(1'b1, 1'b1);

        // Asynchronous reset in the middle of a running stream.
        chk("pre_reset_tvalid", 32'(m_if.tvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tvalid", 32'(m_if.tvalid), 32'd0);
        chk("async_tready", 32'(s_if.tready), 32'd0);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        xs.delete();
        k_out  = 0;
        held_v = 1'b0;
        #1;
        chk("rearm_tready", 32'(s_if.tready), 32'd1);
        for (int c = 0; c < 60; c++) begin
            step(1'b1, 1'b1);
            if (last_out && k_out == 1) chk("restart_phase0", m_if.tdata, xs[0]);
        end
        repeat (20) step(1'b0, 1'b1);
        chk("final_count", 32'(k_out), 32'(exp_count(xs.size())));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
